// File: rtl/xalu_issue_queue.sv
// Issue queue between EX-stage decode and the XALU multiply/divide unit.
// Optional saturating stall counter: define XALU_ISSUE_STATS_EN to add the stall_cnt port.
module xalu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  output logic            req_ready,
  input  logic            hilo_req,
  output logic            drained,
  output logic            stall,
  output logic [OP_W-1:0] XALU_OP,
  output logic [31:0]     A,
  output logic [31:0]     B,
  input  logic            BUSY,
  output logic            bad_op
`ifdef XALU_ISSUE_STATS_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             issue_q;
  logic             hold;

  logic op_onehot;
  logic accept;
  logic push;
  logic issue;

  assign op_onehot = (req_op != '0) && ((req_op & (req_op - 1'b1)) == '0);
  assign req_ready = (count != FULL);
  assign accept    = req_valid & req_ready;
  assign push      = accept & op_onehot;
  // issue_q blocks the start-pulse cycle, hold blocks the cycle before BUSY rises.
  assign issue     = (count != '0) & ~BUSY & ~hold & ~issue_q;

  assign drained = (count == '0) & ~BUSY & ~hold & (XALU_OP == '0);
  assign stall   = (req_valid & ~req_ready) | (hilo_req & ~drained);

  // NOTE: storage array has no reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, a: req_a, b: req_b};
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      issue_q <= 1'b0;
      hold    <= 1'b0;
      XALU_OP <= '0;
      A       <= '0;
      B       <= '0;
      bad_op  <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      issue_q <= issue;
      hold    <= issue_q;
      XALU_OP <= issue ? mem[rd_ptr].op : '0;
      if (issue) begin
        A <= mem[rd_ptr].a;
        B <= mem[rd_ptr].b;
      end
      if (accept && !op_onehot) bad_op <= 1'b1;
    end
  end

`ifdef XALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_xalu_issue_queue.sv
// Self-checking bench for xalu_issue_queue: vector table, scoreboard on issued ops, and
// hand-written full-queue, HI/LO interlock, mid-operation reset and stall-counter sequences.
module tb_xalu_issue_queue;
  localparam int DEPTH = 4;
  localparam int OP_W  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            req_ready;
  logic            hilo_req;
  logic            drained;
  logic            stall;
  logic [OP_W-1:0] XALU_OP;
  logic [31:0]     A;
  logic [31:0]     B;
  logic            BUSY;
  logic            bad_op;
`ifdef XALU_ISSUE_STATS_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     tb_stall_cnt;
`endif

  xalu_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hilo_req  (hilo_req),
    .drained   (drained),
    .stall     (stall),
    .XALU_OP   (XALU_OP),
    .A         (A),
    .B         (B),
    .BUSY      (BUSY),
    .bad_op    (bad_op)
`ifdef XALU_ISSUE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // XALU model: latches the start pulse and stays busy for busy_lat cycles.
  int   busy_lat   = 5;
  logic busy_force = 1'b0;
  int   busy_left;
  assign BUSY = busy_force | (busy_left != 0);

  always @(posedge clk or negedge reset) begin
    if (!reset)                busy_left <= 0;
    else if (XALU_OP != '0)    busy_left <= busy_lat;
    else if (busy_left != 0)   busy_left <= busy_left - 1;
  end

`ifdef XALU_ISSUE_STATS_EN
  always @(posedge clk or negedge reset) begin
    if (!reset)                                tb_stall_cnt <= '0;
    else if (stall && tb_stall_cnt != 16'hFFFF) tb_stall_cnt <= tb_stall_cnt + 1'b1;
  end
`endif

  // Scoreboard of accepted legal requests, checked against each start pulse.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
  } exp_t;
  exp_t sb[$];

  int   cyc        = 0;
  int   last_pulse = -100;
  logic prev_nz    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && XALU_OP != '0) begin
      check("pulse_one_cycle", prev_nz, 1'b0);
      check("pulse_spacing_ge3", (cyc - last_pulse) >= 3, 1'b1);
      last_pulse <= cyc;
      if (sb.size() == 0) begin
        check("unexpected_issue", XALU_OP, '0);
      end else begin
        check("issue_op", XALU_OP, sb[0].op);
        check("issue_a", A, sb[0].a);
        check("issue_b", B, sb[0].b);
        sb.delete(0);
      end
    end
    prev_nz <= (XALU_OP != '0);
  end

  task automatic wait_drained(input int max_cyc, input string name);
    int n = 0;
    while (!drained && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, drained, 1'b1);
  endtask

  typedef struct {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            legal;
    logic            exp_bad;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int   n_stall;
    logic seen_busy;
    logic done;

    vecs[0] = '{4'b0010, 32'h1111_0001, 32'h2222_0001, 1'b1, 1'b0};
    vecs[1] = '{4'b0100, 32'hDEAD_BEEF, 32'h0000_0007, 1'b1, 1'b0};
    vecs[2] = '{4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{4'b0011, 32'hBAD0_0001, 32'hBAD0_0002, 1'b0, 1'b1};
    vecs[4] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1};
    vecs[5] = '{4'b0000, 32'hBAD0_0003, 32'hBAD0_0004, 1'b0, 1'b1};
    vecs[6] = '{4'b1100, 32'hBAD0_0005, 32'hBAD0_0006, 1'b0, 1'b1};
    vecs[7] = '{4'b0010, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b1};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    hilo_req  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_drained", drained, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_xalu_op", XALU_OP, '0);
    check("rst_a", A, '0);
    check("rst_b", B, '0);
    check("rst_bad_op", bad_op, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Single op into an idle queue: start pulse two edges after acceptance.
    busy_lat = 5;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0001; req_a = 32'h0000_1234; req_b = 32'hCABB_FCA8;
    sb.push_back('{4'b0001, 32'h0000_1234, 32'hCABB_FCA8});
    #1;
    check("t1_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("t1_no_pulse_yet", XALU_OP, '0);
    check("t1_not_drained", drained, 1'b0);
    @(negedge clk);
    #1;
    check("t1_pulse_op", XALU_OP, 4'b0001);
    check("t1_pulse_a", A, 32'h0000_1234);
    check("t1_pulse_b", B, 32'hCABB_FCA8);
    @(negedge clk);
    #1;
    check("t1_pulse_end", XALU_OP, '0);
    check("t1_a_held", A, 32'h0000_1234);
    wait_drained(20, "t1_drained");
    check("t1_sb_empty", sb.size(), 0);

    // Vector table: legal ops issue, illegal ones set the sticky bad_op and are dropped.
    busy_lat = 3;
    for (int i = 0; i < 8; i++) begin
      wait_drained(40, "vec_idle");
      @(negedge clk);
      req_valid = 1'b1; req_op = vecs[i].op; req_a = vecs[i].a; req_b = vecs[i].b;
      if (vecs[i].legal) sb.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      #1;
      check("vec_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("vec_bad_op", bad_op, vecs[i].exp_bad);
      check("vec_queued", drained, !vecs[i].legal);
    end
    wait_drained(40, "vec_final_drain");
    check("vec_sb_empty", sb.size(), 0);

    // Queue full: BUSY held, four pushes fill it, a fifth stalls and is dropped.
    busy_force = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'(1 << i); req_a = 32'hA000_0000 + i; req_b = 32'hB000_0000 + i;
      sb.push_back('{4'(1 << i), 32'hA000_0000 + i, 32'hB000_0000 + i});
      #1;
      check("full_push_ready", req_ready, 1'b1);
    end
    @(negedge clk);
    req_op = 4'b0001; req_a = 32'h5555_5555; req_b = 32'h6666_6666;
    #1;
    check("full_ready_low", req_ready, 1'b0);
    check("full_stall", stall, 1'b1);
    @(negedge clk);
    #1;
    check("full_no_push", req_ready, 1'b0);
    req_valid  = 1'b0;
    busy_force = 1'b0;
    busy_lat   = 2;
    wait_drained(100, "full_drained");
    check("full_sb_empty", sb.size(), 0);
`ifdef XALU_ISSUE_STATS_EN
    check("stats_full_cnt", stall_cnt, tb_stall_cnt);
    check("stats_full_one", stall_cnt, 16'd1);
`endif

    // HI/LO interlock with a divide in flight for 10 cycles.
    busy_lat = 10;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0100; req_a = 32'd100; req_b = 32'd7;
    sb.push_back('{4'b0100, 32'd100, 32'd7});
    @(negedge clk);
    req_valid = 1'b0;
    hilo_req  = 1'b1;
    #1;
    n_stall   = 0;
    seen_busy = 1'b0;
    done      = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (seen_busy && !BUSY) begin
        check("hilo_release_stall", stall, 1'b0);
        check("hilo_release_drained", drained, 1'b1);
        done = 1'b1;
      end else begin
        check("hilo_stall", stall, 1'b1);
        n_stall++;
        if (BUSY) seen_busy = 1'b1;
        @(negedge clk);
        #1;
      end
    end
    check("hilo_done", done, 1'b1);
    check("hilo_stall_cycles", n_stall, 12);
    hilo_req = 1'b0;

    // Reset between edges with three entries queued behind a busy XALU.
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'b0010; req_a = 32'hC0DE_0000 + i; req_b = 32'hF00D_0000 + i;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_op", XALU_OP, '0);
    check("mid_rst_a", A, '0);
    check("mid_rst_b", B, '0);
    check("mid_rst_bad_op", bad_op, 1'b0);
    busy_force = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mid_rst_drained", drained, 1'b1);
    check("mid_rst_no_issue_a", A, '0);

`ifdef XALU_ISSUE_STATS_EN
    // Saturation: HI/LO request blocked by a long-busy XALU.
    hilo_req   = 1'b1;
    busy_force = 1'b1;
    repeat (70000) @(negedge clk);
    #1;
    check("stats_sat", stall_cnt, 16'hFFFF);
    check("stats_sat_model", stall_cnt, tb_stall_cnt);
    hilo_req   = 1'b0;
    busy_force = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
